// File: rtl/glitch_filter_pkg.sv
// rtl/glitch_filter_pkg.sv - shared types and defaults for the glitch filter counter
//
// Holds the debounce FSM state encoding and the default parameter values
// used by glitch_filter_counter and its testbench.
package glitch_filter_pkg;

  localparam int GF_STABLE_CYCLES_DEFAULT = 4;
  localparam int GF_CNT_W_DEFAULT         = 8;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } gf_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer
//
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset, clears both flops
//   d_i   - asynchronous input
//   q_o   - synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/glitch_filter_counter.sv
// rtl/glitch_filter_counter.sv - debounced level filter with saturating rising-edge counter
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous active-high reset
//   y_in       - asynchronous, possibly glitchy level from the upstream stage
//   clear      - synchronous clear of edge_count and overflow
//   y_filt     - debounced, synchronized level (registered)
//   rise_pulse - one-cycle strobe in the first cycle y_filt reads 1
//   edge_count - accepted rising transitions since reset/clear, saturating
//   overflow   - sticky, set when a rise is accepted with edge_count saturated
module glitch_filter_counter
  import glitch_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = GF_STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = GF_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             clear,
  output logic             y_filt,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic y_s;

  gf_state_e         state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              y_filt_q, y_filt_d;
  logic              rise_q, rise_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              overflow_q, overflow_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (y_in),
    .q_o   (y_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOW;
      stab_q       <= '0;
      y_filt_q     <= 1'b0;
      rise_q       <= 1'b0;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      y_filt_q     <= y_filt_d;
      rise_q       <= rise_d;
      edge_count_q <= edge_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state logic. The sample that moves LOW->RISE_WAIT (or HIGH->FALL_WAIT)
  // is already the first stable sample, so the counter starts at 1 and the
  // transition is taken when the STABLE_CYCLES-th sample is seen. The counter
  // therefore peaks at STABLE_CYCLES-1 and cannot wrap.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    unique case (state_q)
      ST_LOW: begin
        if (y_s) begin
          state_d = ST_RISE_WAIT;
          stab_d  = STAB_ONE;
        end else begin
          stab_d = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!y_s) begin
          state_d = ST_LOW;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_HIGH;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      ST_HIGH: begin
        if (!y_s) begin
          state_d = ST_FALL_WAIT;
          stab_d  = STAB_ONE;
        end else begin
          stab_d = '0;
        end
      end
      ST_FALL_WAIT: begin
        if (y_s) begin
          state_d = ST_HIGH;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_LOW;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        stab_d  = '0;
      end
    endcase
  end

  // Output logic, registered so y_filt and rise_pulse change on the same
  // edge that the FSM enters HIGH.
  always_comb begin
    y_filt_d = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
    rise_d   = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);
  end

  // Edge counter updates on the same edge as rise_pulse so both are visible
  // together; clear has priority over a coincident rise.
  always_comb begin
    edge_count_d = edge_count_q;
    overflow_d   = overflow_q;
    if (clear) begin
      edge_count_d = '0;
      overflow_d   = 1'b0;
    end else if (rise_d) begin
      if (edge_count_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        edge_count_d = edge_count_q + CNT_ONE;
      end
    end
  end

  assign y_filt     = y_filt_q;
  assign rise_pulse = rise_q;
  assign edge_count = edge_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_glitch_filter_counter.sv
// tb/tb_glitch_filter_counter.sv - directed self-checking bench for glitch_filter_counter
`timescale 1ns/1ps
module tb_glitch_filter_counter;
  import glitch_filter_pkg::*;

  logic       clk;
  logic       reset;
  logic       y_in;
  logic       clear;
  logic       y_filt;
  logic       rise_pulse;
  logic [7:0] edge_count;
  logic       overflow;

  int passed;
  int total;
  logic seen_rise;
  logic seen_high;

  glitch_filter_counter #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .clear      (clear),
    .y_filt     (y_filt),
    .rise_pulse (rise_pulse),
    .edge_count (edge_count),
    .overflow   (overflow)
  );

  // Rising edges at 10, 20, 30, ... ns
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    seen_rise = 1'b0;
    seen_high = 1'b0;
    clear  = 1'b0;
    y_in   = 1'b1;
    reset  = 1'b1;

    // Reset held 25 ns with y_in high: outputs stay 0
    #12;
    check("rst_y_filt", 32'(y_filt), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_count", 32'(edge_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    #13;
    reset = 1'b0;
    // First edge after release is edge 1; y_filt rises on edge 6
    repeat (5) tick();
    check("rst_rel_e5_y_filt", 32'(y_filt), 32'd0);
    tick();
    check("rst_rel_e6_y_filt", 32'(y_filt), 32'd1);
    check("rst_rel_e6_rise", 32'(rise_pulse), 32'd1);
    check("rst_rel_e6_count", 32'(edge_count), 32'd1);
    tick();
    check("rst_rel_e7_rise", 32'(rise_pulse), 32'd0);

    // Fall: y_filt drops on edge 6, no rise_pulse, count unchanged
    y_in = 1'b0;
    seen_rise = 1'b0;
    repeat (5) begin
      tick();
      seen_rise = seen_rise | rise_pulse;
    end
    check("fall_e5_y_filt", 32'(y_filt), 32'd1);
    tick();
    seen_rise = seen_rise | rise_pulse;
    check("fall_e6_y_filt", 32'(y_filt), 32'd0);
    check("fall_no_rise", 32'(seen_rise), 32'd0);
    check("fall_count", 32'(edge_count), 32'd1);
    repeat (3) tick();

    // Clean rise held 100 ns
    y_in = 1'b1;
    repeat (5) tick();
    check("rise_e5_y_filt", 32'(y_filt), 32'd0);
    check("rise_e5_rise", 32'(rise_pulse), 32'd0);
    tick();
    check("rise_e6_y_filt", 32'(y_filt), 32'd1);
    check("rise_e6_rise", 32'(rise_pulse), 32'd1);
    check("rise_e6_count", 32'(edge_count), 32'd2);
    tick();
    check("rise_e7_rise", 32'(rise_pulse), 32'd0);
    check("rise_e7_count", 32'(edge_count), 32'd2);
    repeat (3) tick();
    y_in = 1'b0;
    repeat (8) tick();
    check("rise_back_low", 32'(y_filt), 32'd0);

    // Glitches of 2 and 3 cycles (20 ns, 30 ns) are rejected
    seen_rise = 1'b0;
    seen_high = 1'b0;
    y_in = 1'b1;
    repeat (2) tick();
    y_in = 1'b0;
    repeat (10) begin
      tick();
      seen_rise = seen_rise | rise_pulse;
      seen_high = seen_high | y_filt;
    end
    y_in = 1'b1;
    repeat (3) tick();
    y_in = 1'b0;
    repeat (10) begin
      tick();
      seen_rise = seen_rise | rise_pulse;
      seen_high = seen_high | y_filt;
    end
    check("glitch_y_filt", 32'(seen_high), 32'd0);
    check("glitch_rise", 32'(seen_rise), 32'd0);
    check("glitch_count", 32'(edge_count), 32'd2);

    // A pulse of exactly 4 cycles is accepted
    y_in = 1'b1;
    repeat (4) tick();
    y_in = 1'b0;
    repeat (2) tick();
    check("pulse4_y_filt", 32'(y_filt), 32'd1);
    check("pulse4_rise", 32'(rise_pulse), 32'd1);
    check("pulse4_count", 32'(edge_count), 32'd3);
    repeat (10) tick();
    check("pulse4_back_low", 32'(y_filt), 32'd0);

    // Clear coinciding with an accepted rise: clear wins, pulse still fires
    y_in = 1'b1;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_rise_count", 32'(edge_count), 32'd0);
    check("clr_rise_pulse", 32'(rise_pulse), 32'd1);
    check("clr_rise_y_filt", 32'(y_filt), 32'd1);
    y_in = 1'b0;
    repeat (8) tick();

    // Saturation: 256 clean rises from zero
    for (int i = 0; i < 256; i++) begin
      y_in = 1'b1;
      repeat (6) tick();
      y_in = 1'b0;
      repeat (6) tick();
      if (i == 254) begin
        check("sat255_count", 32'(edge_count), 32'd255);
        check("sat255_ovf", 32'(overflow), 32'd0);
      end
    end
    check("sat256_count", 32'(edge_count), 32'd255);
    check("sat256_ovf", 32'(overflow), 32'd1);
    y_in = 1'b1;
    repeat (6) tick();
    y_in = 1'b0;
    repeat (6) tick();
    check("sat257_count", 32'(edge_count), 32'd255);
    check("sat257_ovf_sticky", 32'(overflow), 32'd1);
    // Clear while filtered level is high: counters zero, y_filt untouched
    y_in = 1'b1;
    repeat (8) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("sat_clr_count", 32'(edge_count), 32'd0);
    check("sat_clr_ovf", 32'(overflow), 32'd0);
    check("sat_clr_y_filt", 32'(y_filt), 32'd1);
    y_in = 1'b0;
    repeat (8) tick();
    check("sat_clr_fall_y_filt", 32'(y_filt), 32'd0);

    // Reset pulsed during RISE_WAIT abandons the pending rise
    y_in = 1'b1;
    repeat (3) tick();
    check("midrst_in_wait", 32'(dut.state_q), 32'(ST_RISE_WAIT));
    y_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(dut.state_q), 32'(ST_LOW));
    check("midrst_y_filt", 32'(y_filt), 32'd0);
    #2;
    reset = 1'b0;
    seen_rise = 1'b0;
    seen_high = 1'b0;
    repeat (10) begin
      tick();
      seen_rise = seen_rise | rise_pulse;
      seen_high = seen_high | y_filt;
    end
    check("midrst_no_rise", 32'(seen_rise), 32'd0);
    check("midrst_no_high", 32'(seen_high), 32'd0);
    check("midrst_count", 32'(edge_count), 32'd0);
    check("midrst_final_state", 32'(dut.state_q), 32'(ST_LOW));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
